// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the IFU/LSU memory arbiter.
package mem_arb_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

    // Watchdog counter width; kept at least 1 bit so a disabled watchdog still elaborates.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant between IFU and LSU; remembers the last winner.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic ifu_valid,
    input  logic lsu_valid,
    output logic ifu_gnt,
    output logic lsu_gnt
);

    req_id_t last_grant_q;

    always_comb begin
        ifu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (en) begin
            if (ifu_valid && lsu_valid) begin
                if (last_grant_q == REQ_LSU) ifu_gnt = 1'b1;
                else                         lsu_gnt = 1'b1;
            end else begin
                ifu_gnt = ifu_valid;
                lsu_gnt = lsu_valid;
            end
        end
    end

    // Reset to LSU so the IFU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       last_grant_q <= REQ_LSU;
        else if (ifu_gnt) last_grant_q <= REQ_IFU;
        else if (lsu_gnt) last_grant_q <= REQ_LSU;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IFU and LSU onto a single-ported memory and sequences one transaction at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned CntW = cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    req_id_t         owner_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            drain_q, drain_d;
    logic            ifu_gnt, lsu_gnt, accept;
    logic            wdog;
    logic            resp_fire, resp_err;
    logic [DATA_W-1:0] resp_data;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_q == ST_IDLE),
        .ifu_valid (ifu_req_valid),
        .lsu_valid (lsu_req_valid),
        .ifu_gnt   (ifu_gnt),
        .lsu_gnt   (lsu_gnt)
    );

    assign ifu_req_ready = ifu_gnt;
    assign lsu_req_ready = lsu_gnt;
    assign accept        = ifu_gnt | lsu_gnt;
    assign mem_req_valid = (state_q == ST_ISSUE);
    assign wdog          = (TIMEOUT != 0) && (cnt_q == CntMax);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        resp_fire = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;
        // A response owed to an abandoned access is swallowed wherever it shows up.
        if (drain_q && mem_resp_valid) drain_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (wdog) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = ST_IDLE;
                    // Memory took the request on the abort cycle, so a response is still owed.
                    if (mem_req_ready) drain_d = 1'b1;
                end else if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_resp_valid && !drain_q) begin
                    resp_fire = 1'b1;
                    resp_data = mem_wen ? '0 : mem_rdata;
                    state_d   = ST_IDLE;
                end else if (wdog) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = ST_IDLE;
                    drain_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= REQ_IFU;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (accept) begin
            owner_q   <= ifu_gnt ? REQ_IFU : REQ_LSU;
            mem_addr  <= ifu_gnt ? ifu_addr : lsu_addr;
            mem_wen   <= lsu_gnt & lsu_wen;
            mem_wdata <= ifu_gnt ? '0 : lsu_wdata;
            mem_wmask <= ifu_gnt ? '0 : lsu_wmask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifu_resp_valid <= 1'b0;
            ifu_resp_err   <= 1'b0;
            ifu_rdata      <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_err   <= 1'b0;
            lsu_rdata      <= '0;
        end else begin
            ifu_resp_valid <= resp_fire && (owner_q == REQ_IFU);
            ifu_resp_err   <= resp_err && (owner_q == REQ_IFU);
            lsu_resp_valid <= resp_fire && (owner_q == REQ_LSU);
            lsu_resp_err   <= resp_err && (owner_q == REQ_LSU);
            if (resp_fire && owner_q == REQ_IFU) ifu_rdata <= resp_data;
            if (resp_fire && owner_q == REQ_LSU) lsu_rdata <= resp_data;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with the default watchdog, one with TIMEOUT=8.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, lsu_req_valid, lsu_wen;
    logic [63:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_ready, mem_resp_valid;

    logic        ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic        lsu_req_ready, lsu_resp_valid, lsu_resp_err;
    logic [63:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
    logic        mem_req_valid, mem_wen;
    logic [7:0]  mem_wmask;

    logic        w_ifu_req_ready, w_ifu_resp_valid, w_ifu_resp_err;
    logic        w_lsu_req_ready, w_lsu_resp_valid, w_lsu_resp_err;
    logic [63:0] w_ifu_rdata, w_lsu_rdata, w_mem_addr, w_mem_wdata;
    logic        w_mem_req_valid, w_mem_wen;
    logic [7:0]  w_mem_wmask;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.TIMEOUT(8)) dut_wd (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(w_ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(w_ifu_resp_valid), .ifu_rdata(w_ifu_rdata),
        .ifu_resp_err(w_ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(w_lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(w_lsu_resp_valid), .lsu_rdata(w_lsu_rdata),
        .lsu_resp_err(w_lsu_resp_err),
        .mem_req_valid(w_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(w_mem_addr),
        .mem_wen(w_mem_wen), .mem_wdata(w_mem_wdata), .mem_wmask(w_mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 0; lsu_req_valid = 0; lsu_wen = 0;
        ifu_addr = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        ncmp++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin nerr++;
            $display("FAIL rst_ready: got %b want 00", {ifu_req_ready, lsu_req_ready}); end
        ncmp++; if ({ifu_resp_valid, ifu_resp_err, lsu_resp_valid, lsu_resp_err, mem_req_valid}
                    !== 5'b0) begin nerr++;
            $display("FAIL rst_flags: got %b want 00000",
                     {ifu_resp_valid, ifu_resp_err, lsu_resp_valid, lsu_resp_err, mem_req_valid});
        end
        ncmp++; if ({mem_addr, mem_wdata, mem_wmask, mem_wen, ifu_rdata, lsu_rdata} !== '0)
            begin nerr++; $display("FAIL rst_fields: got addr %h wdata %h rdata %h/%h want 0",
                                   mem_addr, mem_wdata, ifu_rdata, lsu_rdata); end
        ifu_req_valid = 1; lsu_req_valid = 1;
        #1;
        ncmp++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin nerr++;
            $display("FAIL rst_first_tie: got %b want 10", {ifu_req_ready, lsu_req_ready}); end
    endtask

    task automatic test_ifu_read();
        do_reset();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0000;
        mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 64'h13;
        #1;
        ncmp++; if (ifu_req_ready !== 1'b1) begin nerr++;
            $display("FAIL ifu_rd_ready: got %b want 1", ifu_req_ready); end
        step(); ifu_req_valid = 0; #1;
        ncmp++; if ({mem_req_valid, mem_wen} !== 2'b10 || mem_addr !== 64'h8000_0000) begin
            nerr++; $display("FAIL ifu_rd_issue: got v/wen %b addr %h want 10 80000000",
                             {mem_req_valid, mem_wen}, mem_addr); end
        step(); #1;
        ncmp++; if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0) begin nerr++;
            $display("FAIL ifu_rd_wait: got req %b resp %b want 0 0", mem_req_valid,
                     ifu_resp_valid); end
        step(); #1;
        ncmp++; if ({ifu_resp_valid, ifu_resp_err, lsu_resp_valid} !== 3'b100
                    || ifu_rdata !== 64'h13) begin nerr++;
            $display("FAIL ifu_rd_resp: got v/e/lsu %b rdata %h want 100 13",
                     {ifu_resp_valid, ifu_resp_err, lsu_resp_valid}, ifu_rdata); end
        mem_resp_valid = 0;
        step(); #1;
        ncmp++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin nerr++;
            $display("FAIL ifu_rd_pulse: got %b want 00", {ifu_resp_valid, lsu_resp_valid}); end
    endtask

    task automatic test_alternate();
        logic exp_ifu;
        do_reset();
        ifu_req_valid = 1; lsu_req_valid = 1; ifu_addr = 64'h1000; lsu_addr = 64'h2000;
        mem_req_ready = 1; mem_resp_valid = 1;
        for (int k = 0; k < 4; k++) begin
            exp_ifu = (k % 2 == 0);
            #1;
            ncmp++; if ({ifu_req_ready, lsu_req_ready} !== {exp_ifu, !exp_ifu}) begin nerr++;
                $display("FAIL alt_grant%0d: got %b want %b", k,
                         {ifu_req_ready, lsu_req_ready}, {exp_ifu, !exp_ifu}); end
            if (k > 0) begin
                ncmp++; if ({ifu_resp_valid, lsu_resp_valid} !== {!exp_ifu, exp_ifu}
                            || (exp_ifu ? lsu_rdata : ifu_rdata) !== 64'h100 + 64'(k - 1))
                begin nerr++;
                    $display("FAIL alt_resp%0d: got v %b data %h/%h want %b %h", k - 1,
                             {ifu_resp_valid, lsu_resp_valid}, ifu_rdata, lsu_rdata,
                             {!exp_ifu, exp_ifu}, 64'h100 + 64'(k - 1)); end
            end
            step(); #1;
            ncmp++; if (mem_addr !== (exp_ifu ? 64'h1000 : 64'h2000)) begin nerr++;
                $display("FAIL alt_addr%0d: got %h want %h", k, mem_addr,
                         exp_ifu ? 64'h1000 : 64'h2000); end
            step(); mem_rdata = 64'h100 + 64'(k);
            step();
        end
        #1;
        ncmp++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b01 || lsu_rdata !== 64'h103) begin
            nerr++; $display("FAIL alt_resp3: got v %b data %h want 01 103",
                             {ifu_resp_valid, lsu_resp_valid}, lsu_rdata); end
    endtask

    task automatic test_lsu_write();
        do_reset();
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 64'h8000_0100;
        lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F; mem_rdata = 64'hFFFF;
        #1;
        ncmp++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin nerr++;
            $display("FAIL wr_ready: got %b want 01", {ifu_req_ready, lsu_req_ready}); end
        step(); lsu_req_valid = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            ncmp++; if ({mem_req_valid, mem_wen} !== 2'b11 || mem_wmask !== 8'h0F
                        || mem_addr !== 64'h8000_0100 || mem_wdata !== 64'hDEAD_BEEF) begin
                nerr++; $display("FAIL wr_issue%0d: got v/wen %b mask %h addr %h data %h",
                                 c, {mem_req_valid, mem_wen}, mem_wmask, mem_addr, mem_wdata);
            end
            if (c == 1) mem_req_ready = 1;
            step();
        end
        mem_req_ready = 0; mem_resp_valid = 1;
        step(); mem_resp_valid = 0; #1;
        ncmp++; if ({lsu_resp_valid, lsu_resp_err} !== 2'b10 || lsu_rdata !== 64'h0) begin
            nerr++; $display("FAIL wr_resp: got v/e %b rdata %h want 10 0",
                             {lsu_resp_valid, lsu_resp_err}, lsu_rdata); end
    endtask

    task automatic test_backpressure();
        do_reset();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0040;
        step(); ifu_req_valid = 0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) mem_req_ready = 1;
            #1;
            ncmp++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h8000_0040
                        || mem_wen !== 1'b0) begin nerr++;
                $display("FAIL bp_issue%0d: got v %b addr %h wen %b want 1 80000040 0",
                         c, mem_req_valid, mem_addr, mem_wen); end
            step();
        end
        mem_req_ready = 0;
        for (int c = 5; c <= 9; c++) begin
            if (c == 9) begin mem_resp_valid = 1; mem_rdata = 64'h55; end
            #1;
            ncmp++; if ({mem_req_valid, ifu_resp_valid} !== 2'b00) begin nerr++;
                $display("FAIL bp_wait%0d: got req/resp %b want 00", c,
                         {mem_req_valid, ifu_resp_valid}); end
            step();
        end
        mem_resp_valid = 0; #1;
        ncmp++; if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 64'h55) begin nerr++;
            $display("FAIL bp_resp: got v %b rdata %h want 1 55", ifu_resp_valid, ifu_rdata); end
    endtask

    task automatic test_timeout();
        do_reset();
        ifu_req_valid = 1; ifu_addr = 64'hA0; mem_req_ready = 1;
        step(); ifu_req_valid = 0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            ncmp++; if (w_ifu_resp_valid !== 1'b0) begin nerr++;
                $display("FAIL to_early%0d: got %b want 0", c, w_ifu_resp_valid); end
            step();
        end
        lsu_req_valid = 1; lsu_addr = 64'hB0; #1;
        ncmp++; if ({w_ifu_resp_valid, w_ifu_resp_err} !== 2'b11 || w_ifu_rdata !== 64'h0)
        begin nerr++; $display("FAIL to_err: got v/e %b rdata %h want 11 0",
                               {w_ifu_resp_valid, w_ifu_resp_err}, w_ifu_rdata); end
        ncmp++; if (w_lsu_req_ready !== 1'b1) begin nerr++;
            $display("FAIL to_reaccept: got %b want 1", w_lsu_req_ready); end
        step(); lsu_req_valid = 0;
        step(); mem_resp_valid = 1; mem_rdata = 64'hBAD;
        step(); #1;
        ncmp++; if (w_lsu_resp_valid !== 1'b0) begin nerr++;
            $display("FAIL to_drain: got %b want 0", w_lsu_resp_valid); end
        mem_rdata = 64'h77;
        step(); mem_resp_valid = 0; #1;
        ncmp++; if ({w_lsu_resp_valid, w_lsu_resp_err} !== 2'b10 || w_lsu_rdata !== 64'h77)
        begin nerr++; $display("FAIL to_next: got v/e %b rdata %h want 10 77",
                               {w_lsu_resp_valid, w_lsu_resp_err}, w_lsu_rdata); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0200; mem_req_ready = 1;
        step(); ifu_req_valid = 0;
        step();
        mem_resp_valid = 1; mem_rdata = 64'h99;
        rst_n = 0; #1;
        ncmp++; if ({mem_req_valid, ifu_resp_valid} !== 2'b00 || mem_addr !== 64'h0) begin
            nerr++; $display("FAIL rm_async: got req/resp %b addr %h want 00 0",
                             {mem_req_valid, ifu_resp_valid}, mem_addr); end
        step(); mem_resp_valid = 0; mem_req_ready = 0; rst_n = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            ncmp++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin nerr++;
                $display("FAIL rm_noresp%0d: got %b want 00", c,
                         {ifu_resp_valid, lsu_resp_valid}); end
            step();
        end
        ifu_req_valid = 1; lsu_req_valid = 1; #1;
        ncmp++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin nerr++;
            $display("FAIL rm_tie: got %b want 10", {ifu_req_ready, lsu_req_ready}); end
        ifu_req_valid = 0; lsu_req_valid = 0;
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_alternate();
        test_lsu_write();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
